cursor_draw: RTL
================

Name: cursor_draw

Overview:
- VGA pipeline stage directly downstream of the board-line drawing stage.
- Tracks the player's selected cell on the N²×N² Sudoku-style grid and moves it in response to single-cycle move pulses.
- Overlays a blinking rectangular outline on the selected cell; every other bus field passes through with one register stage.
- Exports the current cursor column and row to game logic.

Parameters:
H_VISIBLE, 800, visible pixels per line
V_VISIBLE, 600, visible lines per frame
CELL_W, 16, cell width in pixels
CELL_H, 16, cell height in pixels
THICK, 2, outline thickness in pixels
BLINK_FRAMES, 30, frames per blink half-period
CURSOR_COLOR, 12'hFF0, outline colour

Ports:
clk  in  1  pixel clock
rst  in  1  reset; asynchronous, active-high
is_game_on  in  1  game active
board_size  in  3  N; valid 2..4; values below 2 are treated as 2, values above 4 as 4
move_up  in  1  single-cycle pulse
move_down  in  1  single-cycle pulse
move_left  in  1  single-cycle pulse
move_right  in  1  single-cycle pulse
cursor_col  out  4  selected column, 0..N²-1
cursor_row  out  4  selected row, 0..N²-1
bus_in  vga_bus  -  upstream stage: hcount 11, vcount 11, hsync, hblnk, vsync, vblnk, rgb 12
bus_out  vga_bus  -  downstream stage, same fields

Behaviour:
- Reset (async, rst=1):
  - all bus_out fields 0
  - cursor_col/cursor_row 0; display copies 0
  - frame counter 0; blink phase 1 (visible)
  - vblnk/board_size history registers cleared
- Pipeline latency: exactly 1 clk for every bus field. bus_out.rgb is CURSOR_COLOR when the draw condition holds, otherwise bus_in.rgb delayed one cycle.
- Geometry (10-bit unsigned, using clamped N):
  - S = N²
  - ox = (H_VISIBLE − CELL_W·S) >> 1; oy = (V_VISIBLE − CELL_H·S) >> 1
  - x0 = ox + disp_col·CELL_W; y0 = oy + disp_row·CELL_H
  - dx = hcount − x0; dy = vcount − y0
- Draw condition: is_game_on && phase && 1 ≤ dx ≤ CELL_W−1 && 1 ≤ dy ≤ CELL_H−1 && (dx ≤ THICK || dx ≥ CELL_W−THICK || dy ≤ THICK || dy ≥ CELL_H−THICK).
  - Offset 0 (the grid line) is never overwritten.
- Movement (evaluated every clk, only when is_game_on=1):
  - Column axis:
    - right alone: col = (col == S−1) ? 0 : col+1
    - left alone: col = (col == 0) ? S−1 : col−1
    - both or neither: no change
  - Row axis: identical rule with down (+1) / up (−1).
  - Axes are independent; a diagonal pair moves both.
  - cursor_col/cursor_row update on the clk edge after the pulse.
- Display latch: disp_col/disp_row copy cursor_col/cursor_row only on a vblnk rising edge (bus_in.vblnk now 1, previous 0). This prevents tearing mid-frame.
- Blink:
  - Each vblnk rising edge increments the frame counter.
  - When the counter equals BLINK_FRAMES−1 and a rising edge arrives, the counter returns to 0 and phase toggles.
  - Any accepted move (a move that changes a cursor value) forces counter=0, phase=1 on the next edge. This overrides a simultaneous toggle.
- Game off (is_game_on=0): cursor and display copies forced to 0, counter 0, phase 1, no overlay, moves ignored.
- board_size change: the clamped N is compared with its registered copy. On a mismatch, cursor and display copies reset to 0 on the next edge.
- Reset asserted mid-frame: outputs go to reset values immediately. After release, the stage resumes pass-through on the next clk.

Test Plan:
- Pass-through: N=3, is_game_on=1, bus_in.rgb=12'h123 at hcount=100, vcount=100 -> bus_out.rgb=12'h123 and all sync/count fields equal bus_in one clk later.
- Overlay geometry: N=3 (ox=328, oy=228), cursor (0,0) latched after a vblnk edge:
  - hcount=329, vcount=240 -> 12'hFF0
  - hcount=328, vcount=240 (grid line) -> bus_in.rgb
  - hcount=336, vcount=236 -> bus_in.rgb
- Wrap-around: N=3, col 0, one move_left -> cursor_col=8. Nine move_right pulses from 0 -> cursor_col=0. Same check for rows with up/down.
- Simultaneous moves: move_left and move_right in the same cycle -> cursor_col unchanged. move_right and move_down together from (2,2) -> (3,3).
- Blink and display latch:
  - after 30 vblnk rising edges with no moves -> phase 0, overlay absent
  - after 30 more -> overlay back
  - a move mid-frame -> overlay position unchanged until the next vblnk edge, then phase=1
- Control: board_size 3→4 with cursor (5,7) -> cursor (0,0). is_game_on=0 -> no overlay, moves ignored. rst pulse mid-line -> bus_out all 0 within the same cycle.

Source files
------------

// File: rtl/cursor_draw_pkg.sv
// Shared VGA pipeline bus payload carried between drawing stages.
package cursor_draw_pkg;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/cursor_draw.sv
// Cursor tracking and blinking cell-outline overlay stage; every bus field is
// registered once, rgb is replaced by the cursor colour on the outline.
module cursor_draw
  import cursor_draw_pkg::*;
#(
  parameter int unsigned H_VISIBLE    = 800,
  parameter int unsigned V_VISIBLE    = 600,
  parameter int unsigned CELL_W       = 16,
  parameter int unsigned CELL_H       = 16,
  parameter int unsigned THICK        = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [11:0] CURSOR_COLOR = 12'hFF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_game_on,
  input  logic [2:0] board_size,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  output logic [3:0] cursor_col,
  output logic [3:0] cursor_row,
  input  vga_bus_t   bus_in,
  output vga_bus_t   bus_out
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [9:0] DX_MAX = 10'(CELL_W - 1);
  localparam logic [9:0] DY_MAX = 10'(CELL_H - 1);
  localparam logic [9:0] DX_HI  = 10'(CELL_W - THICK);
  localparam logic [9:0] DY_HI  = 10'(CELL_H - THICK);
  localparam logic [9:0] THK    = 10'(THICK);

  logic [3:0]       col_q, row_q, dcol_q, drow_q;
  logic [3:0]       col_n, row_n, dcol_n, drow_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             phase_q, phase_n;
  logic             vblnk_q;
  logic [2:0]       n_q;
  vga_bus_t         bus_q, bus_d;

  logic [2:0] n_c;
  logic [4:0] s_c;
  logic [3:0] last_c;
  logic [9:0] ox_c, oy_c, x0_c, y0_c, dx_c, dy_c;
  logic       draw_c, vb_rise_c, moved_c;

  // Clamped board order and centred grid geometry
  always_comb begin
    n_c = board_size;
    if (board_size < 3'd2) n_c = 3'd2;
    else if (board_size > 3'd4) n_c = 3'd4;
    s_c    = 5'(n_c * n_c);
    last_c = 4'(s_c - 5'd1);
    ox_c   = 10'((H_VISIBLE - CELL_W * 32'(s_c)) >> 1);
    oy_c   = 10'((V_VISIBLE - CELL_H * 32'(s_c)) >> 1);
    x0_c   = ox_c + 10'(CELL_W * 32'(dcol_q));
    y0_c   = oy_c + 10'(CELL_H * 32'(drow_q));
    dx_c   = bus_in.hcount[9:0] - x0_c;
    dy_c   = bus_in.vcount[9:0] - y0_c;
  end

  // Outline hit test; offset 0 is the grid line and is left untouched
  always_comb begin
    draw_c = is_game_on && phase_q &&
             (dx_c >= 10'd1) && (dx_c <= DX_MAX) &&
             (dy_c >= 10'd1) && (dy_c <= DY_MAX) &&
             ((dx_c <= THK) || (dx_c >= DX_HI) || (dy_c <= THK) || (dy_c >= DY_HI));
    bus_d     = bus_in;
    bus_d.rgb = draw_c ? CURSOR_COLOR : bus_in.rgb;
  end

  // Cursor movement, tear-free display latch and blink timing
  always_comb begin
    col_n     = col_q;
    row_n     = row_q;
    dcol_n    = dcol_q;
    drow_n    = drow_q;
    cnt_n     = cnt_q;
    phase_n   = phase_q;
    moved_c   = 1'b0;
    vb_rise_c = bus_in.vblnk && !vblnk_q;

    if (!is_game_on) begin
      col_n   = '0;
      row_n   = '0;
      dcol_n  = '0;
      drow_n  = '0;
      cnt_n   = '0;
      phase_n = 1'b1;
    end else begin
      if (n_c != n_q) begin
        col_n  = '0;
        row_n  = '0;
        dcol_n = '0;
        drow_n = '0;
      end else begin
        if (vb_rise_c) begin
          dcol_n = col_q;
          drow_n = row_q;
        end
        if (move_right && !move_left) col_n = (col_q == last_c) ? 4'd0 : col_q + 4'd1;
        if (move_left && !move_right) col_n = (col_q == 4'd0) ? last_c : col_q - 4'd1;
        if (move_down && !move_up)    row_n = (row_q == last_c) ? 4'd0 : row_q + 4'd1;
        if (move_up && !move_down)    row_n = (row_q == 4'd0) ? last_c : row_q - 4'd1;
        moved_c = (col_n != col_q) || (row_n != row_q);
      end

      if (moved_c) begin
        cnt_n   = '0;
        phase_n = 1'b1;
      end else if (vb_rise_c) begin
        if (cnt_q == CNT_LAST) begin
          cnt_n   = '0;
          phase_n = !phase_q;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      dcol_q  <= '0;
      drow_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      vblnk_q <= 1'b0;
      n_q     <= '0;
    end else begin
      bus_q   <= bus_d;
      col_q   <= col_n;
      row_q   <= row_n;
      dcol_q  <= dcol_n;
      drow_q  <= drow_n;
      cnt_q   <= cnt_n;
      phase_q <= phase_n;
      vblnk_q <= bus_in.vblnk;
      n_q     <= n_c;
    end
  end

  assign bus_out    = bus_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule
